// File: rtl/box_overlay_writer.sv
// -----------------------------------------------------------------------------
// box_overlay_writer
//   Draws a 1-pixel rectangle outline into a WIDTH x HEIGHT 16-bit frame buffer
//   via a valid/ready write port. Edges are latched on start_in, validated, and
//   then the outline is written as four lines: top, bottom, left, right.
//   Corners are written twice (once per line).
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous active-low reset
//   start_in        1-cycle pulse, edges valid (ignored unless idle)
//   left_edge_in    box left x
//   right_edge_in   box right x
//   top_edge_in     box top y
//   bot_edge_in     box bottom y
//   wr_ready_in     arbiter accepts the presented write this cycle
//   addr_out        write address (y*WIDTH + x)
//   pixel_data_out  write data, constant BOX_COLOR
//   we_out          write request
//   busy_out        high from start accept until the done cycle
//   done_out        1-cycle pulse when the box is finished
//   err_out         qualified by done_out: edges were rejected, nothing written
// -----------------------------------------------------------------------------
module box_overlay_writer #(
    parameter int          HEIGHT    = 320,
    parameter int          WIDTH     = 240,
    parameter logic [15:0] BOX_COLOR = 16'hF800,
    localparam int         XW        = $clog2(WIDTH),
    localparam int         YW        = $clog2(HEIGHT),
    localparam int         AW        = $clog2(WIDTH*HEIGHT)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start_in,
    input  logic [XW-1:0] left_edge_in,
    input  logic [XW-1:0] right_edge_in,
    input  logic [YW-1:0] top_edge_in,
    input  logic [YW-1:0] bot_edge_in,
    input  logic          wr_ready_in,
    output logic [AW-1:0] addr_out,
    output logic [15:0]   pixel_data_out,
    output logic          we_out,
    output logic          busy_out,
    output logic          done_out,
    output logic          err_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_TOP, S_BOT, S_LEFT, S_RIGHT, S_DONE
    } state_t;

    state_t        state_q;
    logic [XW-1:0] l_q, r_q;
    logic [YW-1:0] t_q, b_q;
    logic [AW-1:0] addr_q;
    logic          we_q, busy_q, done_q, err_q;

    // Row base addresses computed at full address width so legal edges never wrap.
    logic [AW-1:0] top_row, bot_row;
    logic [AW-1:0] top_l, top_r, bot_l, bot_r;
    logic [AW-1:0] phase_end, addr_step;
    logic          xfer, edges_bad;

    assign top_row = AW'(t_q) * AW'(WIDTH);
    assign bot_row = AW'(b_q) * AW'(WIDTH);
    assign top_l   = top_row + AW'(l_q);
    assign top_r   = top_row + AW'(r_q);
    assign bot_l   = bot_row + AW'(l_q);
    assign bot_r   = bot_row + AW'(r_q);

    assign xfer      = we_q && wr_ready_in;
    assign edges_bad = (l_q > r_q) || (t_q > b_q) ||
                       (int'(r_q) >= WIDTH) || (int'(b_q) >= HEIGHT);

    // Horizontal lines walk +1 along a row, vertical lines walk +WIDTH down a column.
    assign addr_step = (state_q == S_LEFT || state_q == S_RIGHT) ? AW'(WIDTH) : AW'(1);

    always_comb begin
        phase_end = bot_r;
        case (state_q)
            S_TOP:   phase_end = top_r;
            S_BOT:   phase_end = bot_r;
            S_LEFT:  phase_end = bot_l;
            S_RIGHT: phase_end = bot_r;
            default: phase_end = bot_r;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            t_q     <= '0;
            b_q     <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        l_q     <= left_edge_in;
                        r_q     <= right_edge_in;
                        t_q     <= top_edge_in;
                        b_q     <= bot_edge_in;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (edges_bad) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        addr_q  <= top_l;
                        we_q    <= 1'b1;
                        state_q <= S_TOP;
                    end
                end
                S_TOP, S_BOT, S_LEFT, S_RIGHT: begin
                    // Address only moves on an accepted write; a stall holds it.
                    if (xfer) begin
                        if (addr_q == phase_end) begin
                            case (state_q)
                                S_TOP: begin
                                    addr_q  <= bot_l;
                                    state_q <= S_BOT;
                                end
                                S_BOT: begin
                                    addr_q  <= top_l;
                                    state_q <= S_LEFT;
                                end
                                S_LEFT: begin
                                    addr_q  <= top_r;
                                    state_q <= S_RIGHT;
                                end
                                default: begin
                                    we_q    <= 1'b0;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= S_DONE;
                                end
                            endcase
                        end else begin
                            addr_q <= addr_q + addr_step;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign addr_out       = addr_q;
    assign pixel_data_out = BOX_COLOR;
    assign we_out         = we_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign err_out        = err_q;

endmodule

// File: tb/tb_box_overlay_writer.sv
// -----------------------------------------------------------------------------
// tb_box_overlay_writer
//   Randomised and directed stimulus for box_overlay_writer. A reference model
//   builds the expected outline address list straight from the box edges; the
//   bench compares every accepted write, the done timing, err and idle state.
// -----------------------------------------------------------------------------
module tb_box_overlay_writer;

    localparam int W = 240;
    localparam int H = 320;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic [7:0]  left_edge_in, right_edge_in;
    logic [8:0]  top_edge_in, bot_edge_in;
    logic        wr_ready_in;
    logic [16:0] addr_out;
    logic [15:0] pixel_data_out;
    logic        we_out, busy_out, done_out, err_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    box_overlay_writer #(.HEIGHT(H), .WIDTH(W), .BOX_COLOR(16'hF800)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .start_in      (start_in),
        .left_edge_in  (left_edge_in),
        .right_edge_in (right_edge_in),
        .top_edge_in   (top_edge_in),
        .bot_edge_in   (bot_edge_in),
        .wr_ready_in   (wr_ready_in),
        .addr_out      (addr_out),
        .pixel_data_out(pixel_data_out),
        .we_out        (we_out),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .err_out       (err_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic bit ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return cyc[0];
        return ($urandom_range(0, 3) != 0);
    endfunction

    // mode: 0 ready tied high, 1 ready low every other cycle, 2 random ready.
    // restart_at: cycle to pulse a bogus start mid-draw (0 = never).
    // start_in_done: pulse start during the done cycle (mode 0 only).
    // abort_after: assert reset once this many writes are accepted (0 = never).
    task automatic run_box(input int L, input int R, input int T, input int B,
                           input int mode, input int restart_at,
                           input bit start_in_done, input int abort_after);
        int          q[$];
        bit          bad;
        int          n, nx, stalls;
        bit          done_seen, prev_stall;
        logic [16:0] prev_addr;

        bad = (L > R) || (T > B) || (R >= W) || (B >= H);
        if (!bad) begin
            for (int x = L; x <= R; x++) q.push_back(T*W + x);
            for (int x = L; x <= R; x++) q.push_back(B*W + x);
            for (int y = T; y <= B; y++) q.push_back(y*W + L);
            for (int y = T; y <= B; y++) q.push_back(y*W + R);
        end
        n          = q.size();
        nx         = 0;
        stalls     = 0;
        done_seen  = 1'b0;
        prev_stall = 1'b0;
        prev_addr  = '0;

        @(posedge clk_in); #1;
        start_in      = 1'b1;
        left_edge_in  = L[7:0];
        right_edge_in = R[7:0];
        top_edge_in   = T[8:0];
        bot_edge_in   = B[8:0];
        wr_ready_in   = ready_for(mode, 0);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk_in);
            if (prev_stall) begin
                chk("hold_addr", addr_out, prev_addr);
                chk("hold_we", we_out, 1);
            end
            prev_stall = we_out && !wr_ready_in;
            if (prev_stall) begin
                prev_addr = addr_out;
                stalls++;
            end
            if (bad) chk("err_no_we", we_out, 0);
            if (cyc == 1) begin
                chk("check_we", we_out, 0);
                chk("check_busy", busy_out, 1);
            end
            if (we_out && wr_ready_in) begin
                if (q.size() == 0) chk("extra_wr", 1, 0);
                else               chk("addr", addr_out, q.pop_front());
                chk("pixel", pixel_data_out, 16'hF800);
                nx++;
                if (abort_after > 0 && nx == abort_after) begin
                    @(posedge clk_in); #1; rst_in = 1'b0; start_in = 1'b0;
                    @(posedge clk_in); #1; rst_in = 1'b1;
                    @(negedge clk_in);
                    chk("rst_we", we_out, 0);
                    chk("rst_busy", busy_out, 0);
                    chk("rst_done", done_out, 0);
                    chk("rst_addr", addr_out, 0);
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk_in);
                        chk("post_rst_we", we_out, 0);
                        chk("post_rst_done", done_out, 0);
                    end
                    return;
                end
            end
            if (done_out) begin
                done_seen = 1'b1;
                chk("done_cyc", cyc, 2 + n + stalls);
                chk("n_writes", nx, n);
                chk("err", err_out, bad);
                chk("done_we", we_out, 0);
                chk("done_busy", busy_out, 0);
                break;
            end
            if (err_out) chk("err_without_done", err_out, 0);
            @(posedge clk_in); #1;
            start_in    = 1'b0;
            wr_ready_in = ready_for(mode, cyc + 1);
            if (restart_at > 0 && cyc + 1 == restart_at) begin
                start_in      = 1'b1;
                left_edge_in  = 8'($urandom);
                right_edge_in = 8'($urandom);
                top_edge_in   = 9'($urandom);
                bot_edge_in   = 9'($urandom);
            end
            if (start_in_done && cyc + 1 == 2 + n) start_in = 1'b1;
        end
        if (!done_seen) chk("timeout", 0, 1);

        @(posedge clk_in); #1;
        start_in    = 1'b0;
        wr_ready_in = 1'b1;
        @(negedge clk_in);
        chk("idle_busy", busy_out, 0);
        chk("idle_we", we_out, 0);
        chk("idle_done", done_out, 0);
    endtask

    initial begin
        rst_in        = 1'b0;
        start_in      = 1'b0;
        wr_ready_in   = 1'b1;
        left_edge_in  = '0;
        right_edge_in = '0;
        top_edge_in   = '0;
        bot_edge_in   = '0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("reset_addr", addr_out, 0);
        chk("reset_we", we_out, 0);
        chk("reset_busy", busy_out, 0);
        chk("reset_done", done_out, 0);
        chk("reset_err", err_out, 0);
        chk("reset_pixel", pixel_data_out, 16'hF800);
        @(posedge clk_in); #1;
        rst_in = 1'b1;

        run_box(10, 19, 20, 29, 0, 0, 0, 0);    // nominal box, ready tied high
        run_box(10, 19, 20, 29, 1, 0, 0, 0);    // stall every other cycle
        run_box(5, 5, 5, 5, 0, 0, 0, 0);        // single pixel, four writes
        run_box(30, 20, 0, 5, 0, 0, 0, 0);      // L > R
        run_box(0, 240, 0, 5, 0, 0, 0, 0);      // R == WIDTH
        run_box(0, 5, 10, 9, 0, 0, 0, 0);       // T > B
        run_box(0, 5, 0, 320, 0, 0, 0, 0);      // B == HEIGHT
        run_box(0, 239, 319, 319, 2, 0, 0, 0);  // full-width single row on last row
        run_box(0, 239, 0, 319, 2, 0, 0, 0);    // full frame border
        run_box(10, 19, 20, 29, 0, 7, 1, 0);    // restart mid-draw and in done cycle
        run_box(10, 19, 20, 29, 0, 0, 0, 25);   // reset during the left line
        run_box(10, 19, 20, 29, 2, 0, 0, 0);    // fresh box after the abort

        for (int i = 0; i < 20; i++) begin
            int L, R, T, B;
            L = $urandom_range(0, 239);
            R = L + $urandom_range(0, 20) - (($urandom_range(0, 7) == 0) ? 25 : 0);
            if (R < 0)   R = 0;
            if (R > 255) R = 255;
            T = $urandom_range(0, 319);
            B = T + $urandom_range(0, 20) - (($urandom_range(0, 7) == 0) ? 25 : 0);
            if (B < 0)   B = 0;
            if (B > 511) B = 511;
            run_box(L, R, T, B, $urandom_range(0, 2), 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
